// File: rtl/if_stage.sv
// if_stage: instruction fetch stage plus the IF/ID pipeline register.
// Keeps the fetch PC, runs a single-outstanding request/response exchange
// with instruction memory and hands inst/pc/pc+4 to decode under the
// stall (enable_i) and flush (reset_i) control of the hazard unit.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt_o and drop_cnt_o counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        reset_i,
    input  logic        br_sel_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc4_d_o,
    output logic        valid_d_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic [31:0] hold_inst_q;
    logic [31:0] hold_pc_q;
    logic        accept;
    logic        req;
    logic [31:0] addr;
    logic        deliver;
    logic        capture;
    logic [31:0] del_inst;
    logic [31:0] del_pc;

    assign accept         = enable_i & ~reset_i;
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = br_target_i & ~32'd3;

    // Next-state, memory request and IF/ID delivery decisions for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        addr     = pc_q;
        deliver  = 1'b0;
        capture  = 1'b0;
        del_inst = hold_inst_q;
        del_pc   = hold_pc_q;
        case (state_q)
            ISSUE: begin
                req     = 1'b1;
                addr    = pc_q;
                state_d = br_sel_i ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (br_sel_i) begin
                        state_d = ISSUE;
                    end else if (accept) begin
                        deliver  = 1'b1;
                        del_inst = imem_rdata_i;
                        del_pc   = pc_q;
                        req      = 1'b1;
                        addr     = pc_plus4;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (br_sel_i) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (br_sel_i) begin
                    state_d = ISSUE;
                end else if (accept) begin
                    deliver = 1'b1;
                    state_d = ISSUE;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    assign imem_req_o  = req & ~rst_i;
    assign imem_addr_o = addr;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC: a redirect always wins, otherwise advance once per accepted response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (br_sel_i) begin
            pc_q <= target_aligned;
        end else if ((state_q == WAIT) && imem_rvalid_i) begin
            pc_q <= pc_plus4;
        end
    end

    // Hold buffer parks a response that decode could not take; only a redirect empties it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_inst_q <= 32'd0;
            hold_pc_q   <= 32'd0;
        end else if (capture) begin
            hold_inst_q <= imem_rdata_i;
            hold_pc_q   <= pc_q;
        end else if ((state_q == HOLD) && br_sel_i) begin
            hold_inst_q <= 32'd0;
            hold_pc_q   <= 32'd0;
        end
    end

    // IF/ID register: hold on stall, otherwise load the delivered instruction or a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_d_o  <= NOP_INST;
            pc_d_o    <= 32'd0;
            pc4_d_o   <= 32'd0;
            valid_d_o <= 1'b0;
        end else if (enable_i) begin
            if (deliver) begin
                inst_d_o  <= del_inst;
                pc_d_o    <= del_pc;
                pc4_d_o   <= del_pc + 32'd4;
                valid_d_o <= 1'b1;
            end else begin
                inst_d_o  <= NOP_INST;
                pc_d_o    <= 32'd0;
                pc4_d_o   <= 32'd0;
                valid_d_o <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic discard;

    assign discard = ((state_q == WAIT) & imem_rvalid_i & br_sel_i)
                   | ((state_q == HOLD) & br_sel_i)
                   | ((state_q == DROP) & imem_rvalid_i);

    // Performance counters: instructions handed to decode and responses thrown away by redirects.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_o <= 32'd0;
            drop_cnt_o  <= 32'd0;
        end else begin
            if (deliver && enable_i) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (discard) begin
                drop_cnt_o <= drop_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table for the fetch corner cases, followed by
// randomized traffic against a transaction-level model of the fetch stream.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        reset_s = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        rs;
        logic        br;
        logic [31:0] tgt;
        logic        rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } vec_t;

    vec_t vecs[$];

    // Free-running clock.
    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .reset_i      (reset_s),
        .br_sel_i     (br),
        .br_target_i  (tgt),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .inst_d_o     (inst),
        .pc_d_o       (pc),
        .pc4_d_o      (pc4),
        .valid_d_o    (valid)
    );

    function automatic vec_t mk(input logic e, input logic r, input logic b,
                                input logic [31:0] t, input logic v, input logic [31:0] d,
                                input logic q, input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] p, input logic [31:0] p4, input logic vl);
        vec_t x;
        x.en = e; x.rs = r; x.br = b; x.tgt = t; x.rv = v; x.rd = d;
        x.req = q; x.addr = a; x.inst = i; x.pc = p; x.pc4 = p4; x.valid = vl;
        return x;
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic r, input logic b, input logic [31:0] t,
                                 input logic v, input logic [31:0] d);
        @(negedge clk);
        rst     = 1'b0;
        enable  = e;
        reset_s = r;
        br      = b;
        tgt     = t;
        rvalid  = v;
        rdata   = d;
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_inst"}, inst, NOP);
        checkOutput({tag, "_pc"}, pc, 32'd0);
        checkOutput({tag, "_pc4"}, pc4, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    // Directed table, reset corner cases, then randomized traffic.
    initial begin
        logic        pending;
        logic [31:0] pend_addr;
        int          resp_cycle;
        logic [31:0] exp_pc;
        logic [31:0] prev_inst, prev_pc, prev_pc4;
        logic        prev_valid;
        logic        req_now;
        logic [31:0] addr_now;
        logic        e, r, b, v;
        logic [31:0] t, d;
        int          delivered;

        // en rs br tgt rv rdata | req addr | inst pc pc4 valid
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         1,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'h0,         1,32'h4,        32'h0,32'h0,32'h4,1));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'h4,         1,32'h8,        32'h4,32'h4,32'h8,1));
        vecs.push_back(mk(0,0,0,32'h0,1'b1,32'h8,         0,32'h0,        32'h4,32'h4,32'h8,1));
        vecs.push_back(mk(0,0,0,32'h0,1'b0,32'h0,         0,32'h0,        32'h4,32'h4,32'h8,1));
        vecs.push_back(mk(0,0,0,32'h0,1'b0,32'h0,         0,32'h0,        32'h4,32'h4,32'h8,1));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         0,32'h0,        32'h8,32'h8,32'hC,1));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         1,32'hC,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'hC,         1,32'h10,       32'hC,32'hC,32'h10,1));
        vecs.push_back(mk(1,0,1,32'h200,1'b1,32'h10,      0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         1,32'h200,      NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'h200,       1,32'h204,      32'h200,32'h200,32'h204,1));
        vecs.push_back(mk(1,1,0,32'h0,1'b1,32'h204,       0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         0,32'h0,        32'h204,32'h204,32'h208,1));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         1,32'h208,      NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,1,32'h103,1'b0,32'h0,       0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'h208,       0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         1,32'h100,      NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         0,32'h0,        NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'h100,       1,32'h104,      32'h100,32'h100,32'h104,1));
        vecs.push_back(mk(1,0,1,32'hFFFF_FFFF,1'b1,32'h104, 0,32'h0,      NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b0,32'h0,         1,32'hFFFF_FFFC, NOP,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,0,32'h0,1'b1,32'hFFFF_FFFC, 1,32'h0,        32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,1));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req", {31'd0, req}, 32'd0);
        checkBubble("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].rs, vecs[i].br, vecs[i].tgt, vecs[i].rv, vecs[i].rd);
            #1;
            checkOutput($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vecs[i].req});
            if (vecs[i].req) begin
                checkOutput($sformatf("v%0d_addr", i), addr, vecs[i].addr);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_inst", i), inst, vecs[i].inst);
            checkOutput($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            checkOutput($sformatf("v%0d_pc4", i), pc4, vecs[i].pc4);
            checkOutput($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].valid});
        end

        // Asynchronous reset in the middle of a WAIT with a request outstanding.
        @(negedge clk);
        enable = 1'b1; reset_s = 1'b0; br = 1'b0; rvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_req", {31'd0, req}, 32'd0);
        checkBubble("async_rst");
        @(posedge clk);
        #1;
        checkOutput("rst_held_req", {31'd0, req}, 32'd0);
        checkBubble("rst_held");

        // Randomized traffic with a variable-latency memory and a fetch-stream model.
        pending    = 1'b0;
        pend_addr  = 32'd0;
        resp_cycle = 0;
        exp_pc     = 32'h0000_0000;
        prev_inst  = NOP;
        prev_pc    = 32'd0;
        prev_pc4   = 32'd0;
        prev_valid = 1'b0;
        delivered  = 0;
        for (int c = 0; c < 1500; c++) begin
            v = pending && (c >= resp_cycle);
            d = v ? memf(pend_addr) : $urandom;
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            applyStimulus(e, r, b, t, v, d);
            #1;
            if (c == 0) begin
                checkOutput("first_req_after_reset", {31'd0, req}, 32'd1);
                checkOutput("first_addr_after_reset", addr, 32'h0);
            end
            if (req) begin
                checkOutput("one_outstanding", {31'd0, pending && !v}, 32'd0);
                checkOutput("req_addr_aligned", {30'd0, addr[1:0]}, 32'd0);
            end
            req_now  = req;
            addr_now = addr;
            @(posedge clk);
            #1;
            if (v) pending = 1'b0;
            if (req_now) begin
                pending    = 1'b1;
                pend_addr  = addr_now;
                resp_cycle = c + $urandom_range(1, 3);
            end
            if (!e) begin
                checkOutput("stall_inst", inst, prev_inst);
                checkOutput("stall_pc", pc, prev_pc);
                checkOutput("stall_pc4", pc4, prev_pc4);
                checkOutput("stall_valid", {31'd0, valid}, {31'd0, prev_valid});
            end else if (r || b) begin
                checkBubble("flush_or_redirect");
            end else if (valid) begin
                checkOutput("stream_pc", pc, exp_pc);
                checkOutput("stream_inst", inst, memf(exp_pc));
                checkOutput("stream_pc4", pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                checkBubble("idle");
            end
            if (b) exp_pc = t & ~32'd3;
            prev_inst  = inst;
            prev_pc    = pc;
            prev_pc4   = pc4;
            prev_valid = valid;
        end
        checkOutput("forward_progress", {31'd0, delivered > 50}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
